// File: rtl/note_seq_pkg.sv
// Shared definitions for the note sequencer: FSM state encoding, oscillator
// counter width and the octave -1 half-period table at 27 MHz.
// Optional tone generation is enabled with NOTE_SEQUENCER_TONE_EN.
package note_seq_pkg;

   typedef enum logic [0:0] {
      ST_STOPPED = 1'b0,
      ST_PLAYING = 1'b1
   } seq_state_e;

   // Oscillator half-period counter width.
   localparam int CNT_W  = 20;

   // C-1..G-1 half-periods exceed 20 bits, so table entries carry one extra
   // bit. Any octave >= 0 shifts them back into the 20-bit counter range.
   localparam int BASE_W = 21;

   // Octave -1 half-period in 27 MHz cycles, indexed by note mod 12 (C = 0).
   function automatic logic [BASE_W-1:0] base_half(input logic [3:0] idx);
      logic [BASE_W-1:0] val;
      case (idx)
         4'd0:    val = 21'd1651215;  // C
         4'd1:    val = 21'd1558539;  // C#
         4'd2:    val = 21'd1471065;  // D
         4'd3:    val = 21'd1388501;  // D#
         4'd4:    val = 21'd1310570;  // E
         4'd5:    val = 21'd1237013;  // F
         4'd6:    val = 21'd1167585;  // F#
         4'd7:    val = 21'd1102054;  // G
         4'd8:    val = 21'd1040200;  // G#
         4'd9:    val = 21'd981818;   // A
         4'd10:   val = 21'd926713;   // A#
         4'd11:   val = 21'd874701;   // B
         default: val = 21'd0;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/tone_osc.sv
// Square-wave tone oscillator for the note sequencer. Present only when
// NOTE_SEQUENCER_TONE_EN is defined; otherwise this file contributes no logic.
`ifdef NOTE_SEQUENCER_TONE_EN
module tone_osc
   import note_seq_pkg::*;
#(
   parameter int NOTE_W = 7
)(
   input  logic              clk_27Mhz,
   input  logic              reset_n,
   input  logic              gate,
   input  logic [NOTE_W-1:0] note,
   output logic              audio_out
);

   logic [3:0]        note_mod_s;
   logic [NOTE_W-1:0] note_oct_s;
   logic [BASE_W-1:0] half_full_s;
   logic [CNT_W-1:0]  half_s;
   logic [CNT_W:0]    cnt_inc_s;
   logic [CNT_W-1:0]  cnt_nxt_s;
   logic              audio_nxt_s;
   logic [CNT_W-1:0]  cnt_r;
   logic              audio_r;
   logic [NOTE_W-1:0] note_prev_r;

   // Half-period for the current note; sub-audio notes that overflow saturate
   always_comb begin
      note_mod_s  = 4'(note % NOTE_W'(12));
      note_oct_s  = note / NOTE_W'(12);
      half_full_s = base_half(note_mod_s) >> note_oct_s;
      if (half_full_s[BASE_W-1:CNT_W] != {(BASE_W-CNT_W){1'b0}}) begin
         half_s = {CNT_W{1'b1}};
      end else begin
         half_s = half_full_s[CNT_W-1:0];
      end
   end

   // Counter/toggle next state: restart silent on gate low or a note change
   always_comb begin
      cnt_inc_s   = {1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1};
      cnt_nxt_s   = cnt_r;
      audio_nxt_s = audio_r;
      if (!gate || (note != note_prev_r)) begin
         cnt_nxt_s   = {CNT_W{1'b0}};
         audio_nxt_s = 1'b0;
      end else if (cnt_inc_s >= {1'b0, half_s}) begin
         cnt_nxt_s   = {CNT_W{1'b0}};
         audio_nxt_s = ~audio_r;
      end else begin
         cnt_nxt_s   = cnt_inc_s[CNT_W-1:0];
         audio_nxt_s = audio_r;
      end
   end

   // Oscillator state registers
   always_ff @(posedge clk_27Mhz) begin
      if (!reset_n) begin
         cnt_r       <= {CNT_W{1'b0}};
         audio_r     <= 1'b0;
         note_prev_r <= {NOTE_W{1'b0}};
      end else begin
         cnt_r       <= cnt_nxt_s;
         audio_r     <= audio_nxt_s;
         note_prev_r <= note;
      end
   end

   assign audio_out = audio_r;

endmodule
`endif

// File: rtl/note_sequencer.sv
// Step sequencer: plays a STEPS-entry note pattern, advancing one step per
// rising edge of the upstream tick. Define NOTE_SEQUENCER_TONE_EN to add the
// square-wave tone oscillator on audio_out; otherwise audio_out is tied low.
module note_sequencer
   import note_seq_pkg::*;
#(
   parameter int STEPS  = 8,
   parameter int NOTE_W = 7
)(
   input  logic                     clk_27Mhz,
   input  logic                     reset_n,
   input  logic                     tick_in,
   input  logic                     run,
   input  logic                     wr_en,
   input  logic [$clog2(STEPS)-1:0] wr_addr,
   input  logic [NOTE_W:0]          wr_data,
   output logic [$clog2(STEPS)-1:0] step_idx,
   output logic [NOTE_W-1:0]        note,
   output logic                     gate,
   output logic                     step_strobe,
   output logic                     audio_out
);

   localparam int              ADDR_W     = $clog2(STEPS);
   localparam logic [NOTE_W:0] REST_ENTRY = {1'b1, {NOTE_W{1'b0}}};

   seq_state_e        state_r, state_nxt_s;
   logic              tick_prev_r;
   logic              rise_s, fall_s;
   logic [NOTE_W:0]   mem_r [STEPS];
   logic [NOTE_W:0]   load_entry_s;
   logic [ADDR_W-1:0] next_ptr_r, ptr_nxt_s;
   logic [ADDR_W-1:0] step_idx_r, idx_nxt_s;
   logic [NOTE_W-1:0] note_r, note_nxt_s;
   logic              gate_r, gate_nxt_s;
   logic              strobe_r, strobe_nxt_s;

   assign rise_s       = tick_in & ~tick_prev_r;
   assign fall_s       = ~tick_in & tick_prev_r;
   assign load_entry_s = mem_r[next_ptr_r];

   // One register of tick history for edge detection
   always_ff @(posedge clk_27Mhz) begin
      if (!reset_n) begin
         tick_prev_r <= 1'b0;
      end else begin
         tick_prev_r <= tick_in;
      end
   end

   // Pattern memory; reset fills with rests and overrides a concurrent write
   always_ff @(posedge clk_27Mhz) begin
      if (!reset_n) begin
         for (int i = 0; i < STEPS; i++) begin
            mem_r[i] <= REST_ENTRY;
         end
      end else if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

   // FSM state register
   always_ff @(posedge clk_27Mhz) begin
      if (!reset_n) begin
         state_r <= ST_STOPPED;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state and step loading; stop wins over a simultaneous tick rise
   always_comb begin
      state_nxt_s  = state_r;
      ptr_nxt_s    = next_ptr_r;
      idx_nxt_s    = step_idx_r;
      note_nxt_s   = note_r;
      gate_nxt_s   = gate_r;
      strobe_nxt_s = 1'b0;
      case (state_r)
         ST_STOPPED: begin
            if (run) begin
               state_nxt_s = ST_PLAYING;
            end else begin
               state_nxt_s = ST_STOPPED;
            end
         end
         ST_PLAYING: begin
            if (!run) begin
               state_nxt_s = ST_STOPPED;
               ptr_nxt_s   = {ADDR_W{1'b0}};
               idx_nxt_s   = {ADDR_W{1'b0}};
               gate_nxt_s  = 1'b0;
            end else if (rise_s) begin
               idx_nxt_s    = next_ptr_r;
               note_nxt_s   = load_entry_s[NOTE_W-1:0];
               gate_nxt_s   = ~load_entry_s[NOTE_W];
               strobe_nxt_s = 1'b1;
               ptr_nxt_s    = next_ptr_r + ADDR_W'(1);
            end else if (fall_s) begin
               gate_nxt_s = 1'b0;
            end else begin
               gate_nxt_s = gate_r;
            end
         end
         default: begin
            state_nxt_s = ST_STOPPED;
            ptr_nxt_s   = {ADDR_W{1'b0}};
            idx_nxt_s   = {ADDR_W{1'b0}};
            gate_nxt_s  = 1'b0;
         end
      endcase
   end

   // Step pointer and sounding-step output registers
   always_ff @(posedge clk_27Mhz) begin
      if (!reset_n) begin
         next_ptr_r <= {ADDR_W{1'b0}};
         step_idx_r <= {ADDR_W{1'b0}};
         note_r     <= {NOTE_W{1'b0}};
         gate_r     <= 1'b0;
         strobe_r   <= 1'b0;
      end else begin
         next_ptr_r <= ptr_nxt_s;
         step_idx_r <= idx_nxt_s;
         note_r     <= note_nxt_s;
         gate_r     <= gate_nxt_s;
         strobe_r   <= strobe_nxt_s;
      end
   end

   assign step_idx    = step_idx_r;
   assign note        = note_r;
   assign gate        = gate_r;
   assign step_strobe = strobe_r;

`ifdef NOTE_SEQUENCER_TONE_EN
   tone_osc #(
      .NOTE_W(NOTE_W)
   ) u_tone_osc (
      .clk_27Mhz (clk_27Mhz),
      .reset_n   (reset_n),
      .gate      (gate_r),
      .note      (note_r),
      .audio_out (audio_out)
   );
`else
   assign audio_out = 1'b0;
`endif

endmodule

// File: tb/tb_note_sequencer.sv
// Directed self-checking bench for note_sequencer. Tone-dependent
// expectations follow NOTE_SEQUENCER_TONE_EN.
module tb_note_sequencer;

   localparam int STEPS  = 8;
   localparam int NOTE_W = 7;

   logic       clk_27Mhz = 1'b0;
   logic       reset_n;
   logic       tick_in;
   logic       run;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [7:0] wr_data;
   logic [2:0] step_idx;
   logic [6:0] note;
   logic       gate;
   logic       step_strobe;
   logic       audio_out;

   int         n_checks = 0;
   int         n_fails  = 0;
   logic [7:0] exp_mem [STEPS];
   int         ptr_m;
   logic       cur_gate;

   always #5 clk_27Mhz = ~clk_27Mhz;

   note_sequencer #(
      .STEPS  (STEPS),
      .NOTE_W (NOTE_W)
   ) dut (
      .clk_27Mhz   (clk_27Mhz),
      .reset_n     (reset_n),
      .tick_in     (tick_in),
      .run         (run),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .step_idx    (step_idx),
      .note        (note),
      .gate        (gate),
      .step_strobe (step_strobe),
      .audio_out   (audio_out)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk_27Mhz);
      #1;
   endtask

   task automatic write_mem(input int addr, input logic [7:0] data);
      wr_en   = 1'b1;
      wr_addr = 3'(addr);
      wr_data = data;
      cyc(1);
      wr_en   = 1'b0;
      exp_mem[addr] = data;
   endtask

   // Raise the tick (optionally with a same-cycle write) and check the load
   task automatic load_step(input bit do_wr, input int waddr, input logic [7:0] wdata);
      int idx;
      idx = ptr_m;
      tick_in = 1'b1;
      if (do_wr) begin
         wr_en   = 1'b1;
         wr_addr = 3'(waddr);
         wr_data = wdata;
      end
      cyc(1);
      wr_en = 1'b0;
      check("strobe_on", 32'(step_strobe), 32'd1);
      check("step_idx", 32'(step_idx), 32'(idx));
      check("note", 32'(note), 32'(exp_mem[idx][6:0]));
      check("gate_on", 32'(gate), 32'(!exp_mem[idx][7]));
      cur_gate = !exp_mem[idx][7];
      if (do_wr) begin
         exp_mem[waddr] = wdata;
      end
      ptr_m = (ptr_m + 1) % STEPS;
      cyc(1);
      check("strobe_off", 32'(step_strobe), 32'd0);
   endtask

   // Drop the tick, check gate falls one edge later, idle out the low half
   task automatic release_step();
      check("gate_held", 32'(gate), 32'(cur_gate));
      tick_in = 1'b0;
      cyc(1);
      check("gate_off", 32'(gate), 32'd0);
      cyc(49);
      check("audio_idle", 32'(audio_out), 32'd0);
   endtask

   task automatic play();
      load_step(1'b0, 0, 8'h00);
      cyc(48);
      release_step();
   endtask

   initial begin
      int n;
      int m;
      logic quiet;
      reset_n = 1'b0;
      tick_in = 1'b0;
      run     = 1'b0;
      wr_en   = 1'b0;
      wr_addr = 3'd0;
      wr_data = 8'h00;
      for (int i = 0; i < STEPS; i++) exp_mem[i] = 8'h80;
      ptr_m    = 0;
      cur_gate = 1'b0;
      cyc(3);
      check("rst_idx", 32'(step_idx), 32'd0);
      check("rst_note", 32'(note), 32'd0);
      check("rst_gate", 32'(gate), 32'd0);
      check("rst_strobe", 32'(step_strobe), 32'd0);
      check("rst_audio", 32'(audio_out), 32'd0);
      reset_n = 1'b1;
      cyc(1);

      // Pattern: notes 0x3C.. with step 3 = A4 (69)
      for (int i = 0; i < STEPS; i++) begin
         write_mem(i, (i == 3) ? 8'h45 : 8'(8'h3C + i));
      end

      // Ticks while stopped are ignored
      tick_in = 1'b1;
      cyc(1);
      check("stopped_strobe", 32'(step_strobe), 32'd0);
      check("stopped_gate", 32'(gate), 32'd0);
      tick_in = 1'b0;
      cyc(2);

      // Full pass 0..7 then wrap to 0, tick period 100 cycles
      run = 1'b1;
      cyc(2);
      repeat (9) play();
      play();
      play();

      // Step 3: A4 tone
      load_step(1'b0, 0, 8'h00);
      check("tone_note", 32'(note), 32'd69);
`ifdef NOTE_SEQUENCER_TONE_EN
      check("tone_audio_at_load", 32'(audio_out), 32'd0);
      n = 0;
      while (audio_out == 1'b0 && n < 40000) begin
         cyc(1);
         n++;
      end
      check("tone_first_toggle_seen", 32'(audio_out), 32'd1);
      m = 0;
      while (audio_out == 1'b1 && m < 40000) begin
         cyc(1);
         m++;
      end
      check("tone_half_period", 32'(m), 32'd30681);
      check("tone_gate_high", 32'(gate), 32'd1);
`else
      quiet = 1'b1;
      repeat (48) begin
         cyc(1);
         if (audio_out !== 1'b0) quiet = 1'b0;
      end
      check("tone_disabled_quiet", 32'(quiet), 32'd1);
      check("tone_gate_high", 32'(gate), 32'd1);
`endif
      release_step();

      // Steps 4..7,0,1, then overwrite step 2 with a rest while it sounds
      repeat (6) play();
      load_step(1'b0, 0, 8'h00);
      cyc(10);
      write_mem(2, 8'h80);
      check("note_hold_after_wr", 32'(note), 32'h3E);
      check("gate_hold_after_wr", 32'(gate), 32'd1);
      cyc(37);
      release_step();

      // Next pass: step 2 is now a rest
      repeat (7) play();
      load_step(1'b0, 0, 8'h00);
      check("rest_note", 32'(note), 32'd0);
      check("rest_gate", 32'(gate), 32'd0);
      check("rest_audio", 32'(audio_out), 32'd0);
      cyc(48);
      release_step();

      // Step 3 loaded in the same cycle it is rewritten: old contents
      load_step(1'b1, 3, 8'h50);
      check("wr_load_old", 32'(note), 32'd69);
      cyc(48);
      release_step();
      repeat (7) play();
      load_step(1'b0, 0, 8'h00);
      check("wr_load_new", 32'(note), 32'h50);
      cyc(48);
      release_step();
      play();

      // Stop in the same cycle as the step 5 rise
      tick_in = 1'b1;
      run     = 1'b0;
      cyc(1);
      check("stop_strobe", 32'(step_strobe), 32'd0);
      check("stop_gate", 32'(gate), 32'd0);
      check("stop_idx", 32'(step_idx), 32'd0);
      check("stop_note_hold", 32'(note), 32'h40);
      cyc(1);
      check("stop_strobe2", 32'(step_strobe), 32'd0);
      tick_in = 1'b0;
      cyc(5);
      run = 1'b1;
      cyc(2);
      ptr_m = 0;
      play();
      load_step(1'b0, 0, 8'h00);
      cyc(10);

      // Reset mid-step with a concurrent write
      reset_n = 1'b0;
      wr_en   = 1'b1;
      wr_addr = 3'd0;
      wr_data = 8'h33;
      cyc(1);
      check("mrst_idx", 32'(step_idx), 32'd0);
      check("mrst_note", 32'(note), 32'd0);
      check("mrst_gate", 32'(gate), 32'd0);
      check("mrst_strobe", 32'(step_strobe), 32'd0);
      check("mrst_audio", 32'(audio_out), 32'd0);
      reset_n = 1'b1;
      wr_en   = 1'b0;
      tick_in = 1'b0;
      for (int i = 0; i < STEPS; i++) exp_mem[i] = 8'h80;
      ptr_m = 0;
      cyc(2);
      repeat (8) play();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
